// File: rtl/field_render_if.sv
// Bundle of video timing, field BRAM read port, updater handshake and pixel output
// shared between field_render (slave) and its environment (master).
interface field_render_if #(
  parameter int CORDW       = 16,
  parameter int FIELD_ADDRW = 6,
  parameter int FIELD_DATAW = 96
) ();
  logic [CORDW-1:0]       sx;
  logic [CORDW-1:0]       sy;
  logic                   de;
  logic                   frame;
  logic                   run;
  logic [FIELD_ADDRW-1:0] field_addr_read;
  logic [FIELD_DATAW-1:0] field_data_out;
  logic                   update_start;
  logic                   update_done;
  logic [3:0]             r;
  logic [3:0]             g;
  logic [3:0]             b;
  logic                   de_out;
  logic [7:0]             overrun;

  modport master (
    output sx, sy, de, frame, run, field_data_out, update_done,
    input  field_addr_read, update_start, r, g, b, de_out, overrun
  );

  modport slave (
    input  sx, sy, de, frame, run, field_data_out, update_done,
    output field_addr_read, update_start, r, g, b, de_out, overrun
  );
endinterface

// File: rtl/field_render.sv
// Renders a vector field as per-cell arrows over a magnitude-coloured background,
// and paces the external field updater once per frame.
module field_render #(
  parameter int FIELD_WIDTH  = 8,
  parameter int FIELD_HEIGHT = 6,
  parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  parameter int FIELD_DATAW  = 96,
  parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
  parameter int BLOCK_SIZE   = 80,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int CORDW        = 16,
  parameter int ARROW_HALF_W = 2,
  parameter int MAG_SHIFT    = 0
) (
  input  logic            clk,
  input  logic            rst,
  field_render_if.slave   io_fr
);
  localparam int OFFW  = $clog2(BLOCK_SIZE);
  localparam int CXW   = $clog2(FIELD_WIDTH + 1);
  localparam int CYW   = $clog2(FIELD_HEIGHT + 1);
  localparam int DXW   = OFFW + 1;
  localparam int PRODW = 48;
  localparam int HALF  = BLOCK_SIZE / 2;

  localparam logic signed [DXW-1:0]   DX_EDGE = DXW'(-HALF);
  localparam logic signed [31:0]      LEN_MAX = 32'((HALF - 1) << 16);
  localparam logic signed [31:0]      MAG16   = 32'sh0010_0000;
  localparam logic signed [PRODW-1:0] HALF_W  = PRODW'(ARROW_HALF_W << 16);

  // ---------------- cell tracking (stage 0) ----------------
  logic [OFFW-1:0] r_off_x, r_off_y, w_off_x, w_off_y;
  logic [CXW-1:0]  r_cell_x, w_cell_x;
  logic [CYW-1:0]  r_cell_y, w_cell_y;
  logic            w_x0, w_y0, w_xwrap, w_ywrap, w_line_end;

  assign w_x0       = (io_fr.sx == '0);
  assign w_y0       = (io_fr.sy == '0);
  assign w_off_x    = w_x0 ? '0 : r_off_x;
  assign w_cell_x   = w_x0 ? '0 : r_cell_x;
  assign w_off_y    = w_y0 ? '0 : r_off_y;
  assign w_cell_y   = w_y0 ? '0 : r_cell_y;
  assign w_xwrap    = (w_off_x == OFFW'(BLOCK_SIZE - 1));
  assign w_ywrap    = (w_off_y == OFFW'(BLOCK_SIZE - 1));
  assign w_line_end = io_fr.de && (io_fr.sx == CORDW'(H_RES - 1));

  // Registers hold the position of the pixel that follows the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_off_x  <= '0;
      r_cell_x <= '0;
      r_off_y  <= '0;
      r_cell_y <= '0;
    end else begin
      if (io_fr.de) begin
        if (w_xwrap) begin
          r_off_x  <= '0;
          r_cell_x <= w_cell_x + 1'b1;
        end else begin
          r_off_x  <= w_off_x + 1'b1;
          r_cell_x <= w_cell_x;
        end
      end
      if (w_line_end) begin
        if (w_ywrap) begin
          r_off_y  <= '0;
          r_cell_y <= w_cell_y + 1'b1;
        end else begin
          r_off_y  <= w_off_y + 1'b1;
          r_cell_y <= w_cell_y;
        end
      end else begin
        r_off_y  <= w_off_y;
        r_cell_y <= w_cell_y;
      end
    end
  end

  // ---------------- stages 1-2: address, BRAM read ----------------
  logic [FIELD_ADDRW-1:0] r_addr;
  logic [OFFW-1:0]        r1_off_x, r1_off_y, r2_off_x, r2_off_y;
  logic                   r1_de, r2_de;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r1_off_x <= '0;
      r1_off_y <= '0;
      r1_de    <= 1'b0;
      r2_off_x <= '0;
      r2_off_y <= '0;
      r2_de    <= 1'b0;
    end else begin
      r_addr   <= FIELD_ADDRW'(w_cell_y) * FIELD_ADDRW'(FIELD_WIDTH) + FIELD_ADDRW'(w_cell_x);
      r1_off_x <= w_off_x;
      r1_off_y <= w_off_y;
      r1_de    <= io_fr.de;
      r2_off_x <= r1_off_x;
      r2_off_y <= r1_off_y;
      r2_de    <= r1_de;
    end
  end

  // ---------------- stage 3: offsets from cell centre and products ----------------
  logic signed [31:0]      w_xn, w_yn, w_mag;
  logic signed [DXW-1:0]   w_dx, w_dy;
  logic signed [PRODW-1:0] w_cross, w_dot;

  assign w_xn    = $signed(io_fr.field_data_out[FIELD_DATAW-1 -: 32]);
  assign w_yn    = $signed(io_fr.field_data_out[FIELD_DATAW-33 -: 32]);
  assign w_mag   = $signed(io_fr.field_data_out[FIELD_DATAW-65 -: 32]);
  assign w_dx    = $signed(DXW'(r2_off_x)) - $signed(DXW'(HALF));
  assign w_dy    = $signed(DXW'(r2_off_y)) - $signed(DXW'(HALF));
  assign w_cross = (PRODW'(w_dx) * PRODW'(w_yn)) - (PRODW'(w_dy) * PRODW'(w_xn));
  assign w_dot   = (PRODW'(w_dx) * PRODW'(w_xn)) + (PRODW'(w_dy) * PRODW'(w_yn));

  logic signed [DXW-1:0]   r3_dx, r3_dy;
  logic signed [PRODW-1:0] r3_cross, r3_dot;
  logic signed [31:0]      r3_mag;
  logic                    r3_de;

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_dx    <= '0;
      r3_dy    <= '0;
      r3_cross <= '0;
      r3_dot   <= '0;
      r3_mag   <= '0;
      r3_de    <= 1'b0;
    end else begin
      r3_dx    <= w_dx;
      r3_dy    <= w_dy;
      r3_cross <= w_cross;
      r3_dot   <= w_dot;
      r3_mag   <= w_mag;
      r3_de    <= r2_de;
    end
  end

  // ---------------- stage 4: colour ----------------
  logic signed [31:0] w_mag_sh, w_len;
  logic               w_grid, w_arrow;
  logic [3:0]         w_int;

  assign w_mag_sh = r3_mag >>> MAG_SHIFT;
  assign w_len    = (w_mag_sh > LEN_MAX) ? LEN_MAX : w_mag_sh;
  // Offset 0 inside a cell is the same as dx/dy sitting at the most negative value.
  assign w_grid   = (r3_dx == DX_EDGE) || (r3_dy == DX_EDGE);
  assign w_arrow  = (r3_cross <= HALF_W) && (r3_cross >= -HALF_W) &&
                    !r3_dot[PRODW-1] && (r3_dot <= PRODW'(w_len));
  assign w_int    = (r3_mag[31] || (r3_mag >= MAG16)) ? 4'hF : r3_mag[19:16];

  logic [3:0] r_red, r_grn, r_blu;
  logic       r_de_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_red    <= '0;
      r_grn    <= '0;
      r_blu    <= '0;
      r_de_out <= 1'b0;
    end else begin
      r_de_out <= r3_de;
      if (!r3_de) begin
        r_red <= 4'h0; r_grn <= 4'h0; r_blu <= 4'h0;
      end else if (w_grid) begin
        r_red <= 4'h4; r_grn <= 4'h4; r_blu <= 4'h4;
      end else if (w_arrow) begin
        r_red <= 4'hF; r_grn <= 4'hF; r_blu <= 4'hF;
      end else begin
        r_red <= w_int; r_grn <= 4'h0; r_blu <= ~w_int;
      end
    end
  end

  // ---------------- update pacing FSM ----------------
  typedef enum logic [0:0] {ST_IDLE, ST_UPDATING} state_t;
  state_t     r_state;
  logic       r_update_start;
  logic [7:0] r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_update_start <= 1'b0;
      r_overrun      <= '0;
    end else begin
      r_update_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_fr.frame && io_fr.run) begin
            r_update_start <= 1'b1;
            r_state        <= ST_UPDATING;
          end
        end
        ST_UPDATING: begin
          // A frame coinciding with completion chains straight into the next update.
          if (io_fr.update_done) begin
            if (io_fr.frame && io_fr.run) r_update_start <= 1'b1;
            else                          r_state        <= ST_IDLE;
          end else if (io_fr.frame && io_fr.run && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_fr.field_addr_read = r_addr;
  assign io_fr.update_start    = r_update_start;
  assign io_fr.overrun         = r_overrun;
  assign io_fr.r               = r_red;
  assign io_fr.g               = r_grn;
  assign io_fr.b               = r_blu;
  assign io_fr.de_out          = r_de_out;
endmodule

// File: tb/tb_field_render.sv
// Directed bench for field_render: shortened scan lines feed the pixel pipeline,
// then the update pacing FSM is exercised cycle by cycle.
module tb_field_render;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  field_render_if #(.CORDW(16), .FIELD_ADDRW(6), .FIELD_DATAW(96)) bus ();

  field_render dut (
    .clk   (clk),
    .rst   (rst),
    .io_fr (bus)
  );

  // Field BRAM model with one-cycle registered read.
  logic [95:0] mem [48];
  logic [95:0] bram_q;
  always_ff @(posedge clk) bram_q <= mem[bus.field_addr_read];
  assign bus.field_data_out = bram_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         x;
    int         y;
    logic       de;
    logic [11:0] rgb;
    logic       ck_addr;
    logic [5:0] addr;
  } tgt_t;

  tgt_t tgts[$];
  int   n_hit = 0;
  int   hx[4];
  int   hy[4];
  logic hde[4];

  function automatic void add_tgt(input int x, input int y, input logic de,
                                  input logic [11:0] rgb, input logic ck, input logic [5:0] a);
    tgt_t t;
    t.x = x; t.y = y; t.de = de; t.rgb = rgb; t.ck_addr = ck; t.addr = a;
    tgts.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel; outputs of the pixel presented 4 edges earlier are checked.
  task automatic drive(input int x, input int y, input logic d);
    bus.sx = 16'(x);
    bus.sy = 16'(y);
    bus.de = d;
    tick();
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1]; hy[i] = hy[i-1]; hde[i] = hde[i-1];
    end
    hx[0] = x; hy[0] = y; hde[0] = d;
    foreach (tgts[k]) begin
      if (tgts[k].ck_addr && hx[0] == tgts[k].x && hy[0] == tgts[k].y && hde[0] == tgts[k].de)
        chk($sformatf("addr(%0d,%0d)", hx[0], hy[0]), 32'(bus.field_addr_read), 32'(tgts[k].addr));
      if (hx[3] == tgts[k].x && hy[3] == tgts[k].y && hde[3] == tgts[k].de) begin
        n_hit++;
        chk($sformatf("rgb(%0d,%0d)", hx[3], hy[3]), {20'b0, bus.r, bus.g, bus.b}, 32'(tgts[k].rgb));
        chk($sformatf("de_out(%0d,%0d)", hx[3], hy[3]), 32'(bus.de_out), 32'(tgts[k].de));
        $display("pix (%0d,%0d) de=%0b rgb=%0h exp=%0h", hx[3], hy[3], bus.de_out,
                 {bus.r, bus.g, bus.b}, tgts[k].rgb);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 48; i++) mem[i] = '0;
    mem[0] = {32'h0001_0000, 32'h0000_0000, 32'h0014_0000};
    mem[1] = {32'h0000_0000, 32'h0001_0000, 32'h0005_0000};
    mem[2] = {32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    mem[3] = {32'h0002_0000, 32'h0000_0000, 32'h0064_0000};
    mem[9] = {32'hFFFF_0000, 32'h0000_0000, 32'h0014_0000};
    for (int i = 0; i < 4; i++) begin hx[i] = -1; hy[i] = -1; hde[i] = 1'b0; end

    add_tgt(40, 40, 1'b1, 12'hFFF, 1'b1, 6'd0);   // arrow centre
    add_tgt(60, 40, 1'b1, 12'hFFF, 1'b0, 6'd0);   // tip at exactly len
    add_tgt(61, 40, 1'b1, 12'hF00, 1'b0, 6'd0);   // past tip
    add_tgt(39, 40, 1'b1, 12'hF00, 1'b0, 6'd0);   // behind centre, dot<0
    add_tgt(50, 42, 1'b1, 12'hFFF, 1'b0, 6'd0);   // |cross| at half-width
    add_tgt(50, 43, 1'b1, 12'hF00, 1'b0, 6'd0);   // just outside width
    add_tgt(299, 40, 1'b1, 12'hFFF, 1'b1, 6'd3);  // under clamped length
    add_tgt(300, 40, 1'b1, 12'hF00, 1'b0, 6'd3);  // beyond 39.0 clamp
    add_tgt(80, 10, 1'b1, 12'h444, 1'b1, 6'd1);   // grid line
    add_tgt(100, 10, 1'b1, 12'h50A, 1'b0, 6'd1);  // background I=5
    add_tgt(170, 10, 1'b1, 12'hF00, 1'b1, 6'd2);  // negative mag
    add_tgt(130, 120, 1'b1, 12'hF00, 1'b1, 6'd9); // dot -10.0
    add_tgt(5, 5, 1'b0, 12'h000, 1'b0, 6'd0);     // blanking

    rst = 1'b1;
    bus.sx = '0; bus.sy = '0; bus.de = 1'b0;
    bus.frame = 1'b0; bus.run = 1'b0; bus.update_done = 1'b0;
    repeat (3) tick();
    chk("rst_addr", 32'(bus.field_addr_read), 32'd0);
    chk("rst_rgb", {20'b0, bus.r, bus.g, bus.b}, 32'h0);
    chk("rst_de_out", 32'(bus.de_out), 32'd0);
    chk("rst_start", 32'(bus.update_start), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;

    // Only rows with targets are scanned wide; every line ends on its last active pixel.
    for (int y = 0; y <= 120; y++) begin
      int w;
      w = (y == 10 || y == 40 || y == 42 || y == 43 || y == 120) ? 330 : 4;
      for (int x = 0; x < w; x++) drive(x, y, 1'b1);
      drive(639, y, 1'b1);
    end
    drive(5, 5, 1'b0);
    repeat (4) drive(0, 0, 1'b0);
    chk("targets_hit", 32'(n_hit), 32'(tgts.size()));

    // Update pacing
    bus.run = 1'b1; bus.frame = 1'b1; tick();
    chk("start_first", 32'(bus.update_start), 32'd1);
    $display("fsm frame -> start=%0b", bus.update_start);
    bus.frame = 1'b0; tick();
    chk("start_one_cycle", 32'(bus.update_start), 32'd0);
    bus.frame = 1'b1; tick();
    chk("busy_no_start", 32'(bus.update_start), 32'd0);
    chk("overrun_1", 32'(bus.overrun), 32'd1);
    $display("fsm busy frame -> overrun=%0d", bus.overrun);
    bus.frame = 1'b0; bus.update_done = 1'b1; tick();
    bus.update_done = 1'b0;
    chk("done_no_start", 32'(bus.update_start), 32'd0);
    bus.frame = 1'b1; tick();
    chk("start_after_done", 32'(bus.update_start), 32'd1);
    bus.frame = 1'b0; tick();
    bus.frame = 1'b1; bus.update_done = 1'b1; tick();
    chk("start_chained", 32'(bus.update_start), 32'd1);
    chk("overrun_kept", 32'(bus.overrun), 32'd1);
    $display("fsm frame+done -> start=%0b overrun=%0d", bus.update_start, bus.overrun);
    bus.update_done = 1'b0;
    repeat (300) tick();
    bus.frame = 1'b0;
    chk("overrun_sat", 32'(bus.overrun), 32'd255);
    chk("no_start_sat", 32'(bus.update_start), 32'd0);
    $display("fsm 300 skipped -> overrun=%0d", bus.overrun);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst_mid_start", 32'(bus.update_start), 32'd0);
    chk("rst_mid_overrun", 32'(bus.overrun), 32'd0);
    bus.update_done = 1'b1; tick();
    bus.update_done = 1'b0;
    bus.run = 1'b0; bus.frame = 1'b1; tick();
    chk("run_low_no_start", 32'(bus.update_start), 32'd0);
    chk("run_low_no_overrun", 32'(bus.overrun), 32'd0);
    bus.run = 1'b1; tick();
    chk("start_after_rst", 32'(bus.update_start), 32'd1);
    $display("fsm after rst frame -> start=%0b", bus.update_start);
    bus.frame = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
